// File: rtl/cc_comparator_bank.sv
// rtl/cc_comparator_bank.sv - registered multi-channel threshold comparator with per-channel persistence qualification
module cc_comparator_bank #(
    parameter int NUMBER_DATAWIDTH    = 8,
    parameter int NUMBER_CHANNELS     = 4,
    parameter int NUMBER_SIGNED       = 0,
    parameter int NUMBER_PERSISTWIDTH = 4
) (
    input  logic                                        CC_COMPARATOR_BANK_CLOCK_50,
    input  logic                                        CC_COMPARATOR_BANK_RESET_InHigh,
    input  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0] CC_COMPARATOR_BANK_data_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0]                 CC_COMPARATOR_BANK_threshold_InBUS,
    input  logic [1:0]                                  CC_COMPARATOR_BANK_mode_InBUS,
    input  logic [NUMBER_PERSISTWIDTH-1:0]              CC_COMPARATOR_BANK_persist_InBUS,
    input  logic                                        CC_COMPARATOR_BANK_valid_In,
    output logic [NUMBER_CHANNELS-1:0]                  CC_COMPARATOR_BANK_result_OutBUS,
    output logic [NUMBER_CHANNELS-1:0]                  CC_COMPARATOR_BANK_fire_OutBUS,
    output logic                                        CC_COMPARATOR_BANK_valid_Out
);

    localparam int W  = NUMBER_DATAWIDTH;
    localparam int CH = NUMBER_CHANNELS;
    localparam int PW = NUMBER_PERSISTWIDTH;

    localparam logic [PW-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0] CNT_ONE = PW'(1);
    // Flipping the MSB maps two's-complement ordering onto unsigned ordering,
    // so one unsigned comparator serves both signedness settings.
    localparam logic [W-1:0]  BIAS    = {NUMBER_SIGNED != 0, {(W-1){1'b0}}};

    logic [CH-1:0] hit;
    logic [CH-1:0] fire_next;
    logic [PW-1:0] cnt      [CH];
    logic [PW-1:0] cnt_inc  [CH];
    logic [PW-1:0] p_eff;
    logic [W-1:0]  t_key;
    logic [W-1:0]  d_key;

    always_comb begin
        hit       = '0;
        fire_next = '0;
        d_key     = '0;
        t_key     = CC_COMPARATOR_BANK_threshold_InBUS ^ BIAS;
        p_eff     = (CC_COMPARATOR_BANK_persist_InBUS == '0) ? CNT_ONE
                                                             : CC_COMPARATOR_BANK_persist_InBUS;
        for (int i = 0; i < CH; i++) begin
            d_key = CC_COMPARATOR_BANK_data_InBUS[i*W +: W] ^ BIAS;
            case (CC_COMPARATOR_BANK_mode_InBUS)
                2'b00:   hit[i] = (d_key <= t_key);
                2'b01:   hit[i] = (d_key <  t_key);
                2'b10:   hit[i] = (d_key >= t_key);
                default: hit[i] = (d_key == t_key);
            endcase
            cnt_inc[i]   = (cnt[i] == CNT_MAX) ? CNT_MAX : cnt[i] + CNT_ONE;
            fire_next[i] = hit[i] && (cnt_inc[i] >= p_eff);
        end
    end

    always_ff @(posedge CC_COMPARATOR_BANK_CLOCK_50) begin
        if (CC_COMPARATOR_BANK_RESET_InHigh) begin
            CC_COMPARATOR_BANK_result_OutBUS <= '0;
            CC_COMPARATOR_BANK_fire_OutBUS   <= '0;
            CC_COMPARATOR_BANK_valid_Out     <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            CC_COMPARATOR_BANK_valid_Out <= CC_COMPARATOR_BANK_valid_In;
            if (CC_COMPARATOR_BANK_valid_In) begin
                CC_COMPARATOR_BANK_result_OutBUS <= hit;
                CC_COMPARATOR_BANK_fire_OutBUS   <= fire_next;
                for (int i = 0; i < CH; i++) begin
                    cnt[i] <= hit[i] ? cnt_inc[i] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cc_comparator_bank.sv
// tb/tb_cc_comparator_bank.sv - directed-vector bench for cc_comparator_bank
module tb_cc_comparator_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  threshold;
    logic [1:0]  mode;
    logic [3:0]  persist;
    logic [1:0]  persist_p2;
    logic        valid;

    logic [3:0]  res_u, fire_u, res_s, fire_s, res_p, fire_p;
    logic        vout_u, vout_s, vout_p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cc_comparator_bank #(.NUMBER_DATAWIDTH(8), .NUMBER_CHANNELS(4),
                         .NUMBER_SIGNED(0), .NUMBER_PERSISTWIDTH(4)) u_dut (
        .CC_COMPARATOR_BANK_CLOCK_50       (clk),
        .CC_COMPARATOR_BANK_RESET_InHigh   (rst),
        .CC_COMPARATOR_BANK_data_InBUS     (data),
        .CC_COMPARATOR_BANK_threshold_InBUS(threshold),
        .CC_COMPARATOR_BANK_mode_InBUS     (mode),
        .CC_COMPARATOR_BANK_persist_InBUS  (persist),
        .CC_COMPARATOR_BANK_valid_In       (valid),
        .CC_COMPARATOR_BANK_result_OutBUS  (res_u),
        .CC_COMPARATOR_BANK_fire_OutBUS    (fire_u),
        .CC_COMPARATOR_BANK_valid_Out      (vout_u)
    );

    cc_comparator_bank #(.NUMBER_DATAWIDTH(8), .NUMBER_CHANNELS(4),
                         .NUMBER_SIGNED(1), .NUMBER_PERSISTWIDTH(4)) u_dut_signed (
        .CC_COMPARATOR_BANK_CLOCK_50       (clk),
        .CC_COMPARATOR_BANK_RESET_InHigh   (rst),
        .CC_COMPARATOR_BANK_data_InBUS     (data),
        .CC_COMPARATOR_BANK_threshold_InBUS(threshold),
        .CC_COMPARATOR_BANK_mode_InBUS     (mode),
        .CC_COMPARATOR_BANK_persist_InBUS  (persist),
        .CC_COMPARATOR_BANK_valid_In       (valid),
        .CC_COMPARATOR_BANK_result_OutBUS  (res_s),
        .CC_COMPARATOR_BANK_fire_OutBUS    (fire_s),
        .CC_COMPARATOR_BANK_valid_Out      (vout_s)
    );

    cc_comparator_bank #(.NUMBER_DATAWIDTH(8), .NUMBER_CHANNELS(4),
                         .NUMBER_SIGNED(0), .NUMBER_PERSISTWIDTH(2)) u_dut_p2 (
        .CC_COMPARATOR_BANK_CLOCK_50       (clk),
        .CC_COMPARATOR_BANK_RESET_InHigh   (rst),
        .CC_COMPARATOR_BANK_data_InBUS     (data),
        .CC_COMPARATOR_BANK_threshold_InBUS(threshold),
        .CC_COMPARATOR_BANK_mode_InBUS     (mode),
        .CC_COMPARATOR_BANK_persist_InBUS  (persist_p2),
        .CC_COMPARATOR_BANK_valid_In       (valid),
        .CC_COMPARATOR_BANK_result_OutBUS  (res_p),
        .CC_COMPARATOR_BANK_fire_OutBUS    (fire_p),
        .CC_COMPARATOR_BANK_valid_Out      (vout_p)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        step();
        rst   = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        data       = '0;
        threshold  = '0;
        mode       = 2'b00;
        persist    = 4'd1;
        persist_p2 = 2'd0;
        valid      = 1'b0;

        // reset and one-cycle latency
        step();
        step();
        check("reset_result", res_u, 4'b0000);
        check("reset_fire",   fire_u, 4'b0000);
        check("reset_valid",  vout_u, 1'b0);
        rst       = 1'b0;
        mode      = 2'b00;
        threshold = 8'h40;
        persist   = 4'd1;
        data      = {8'hFF, 8'h41, 8'h40, 8'h30};
        valid     = 1'b1;
        step();
        check("lat_result", res_u, 4'b0011);
        check("lat_fire",   fire_u, 4'b0011);
        check("lat_valid",  vout_u, 1'b1);
        valid = 1'b0;
        step();
        check("lat_valid_pulse", vout_u, 1'b0);
        check("lat_hold_result", res_u, 4'b0011);

        // persistence run of three, then a miss clears the counter
        do_reset();
        check("rst2_fire", fire_u, 4'b0000);
        persist   = 4'd3;
        mode      = 2'b10;
        threshold = 8'h10;
        data      = {8'h00, 8'h00, 8'h00, 8'h20};
        valid     = 1'b1;
        step();
        check("pers_fire_1",   fire_u, 4'b0000);
        check("pers_result_1", res_u,  4'b0001);
        step();
        check("pers_fire_2", fire_u, 4'b0000);
        step();
        check("pers_fire_3", fire_u, 4'b0001);
        data = {8'h00, 8'h00, 8'h00, 8'h05};
        step();
        check("pers_miss_result", res_u,  4'b0000);
        check("pers_miss_fire",   fire_u, 4'b0000);
        data = {8'h00, 8'h00, 8'h00, 8'h20};
        step();
        check("pers_cleared_fire", fire_u, 4'b0000);

        // gaps hold state and do not break a run
        do_reset();
        persist = 4'd2;
        valid   = 1'b1;
        step();
        check("gap_first_fire", fire_u, 4'b0000);
        valid = 1'b0;
        data  = {8'h00, 8'h00, 8'h00, 8'h01};
        for (int i = 0; i < 5; i++) begin
            step();
            check("gap_valid_out", vout_u, 1'b0);
            check("gap_hold_res",  res_u,  4'b0001);
            check("gap_hold_fire", fire_u, 4'b0000);
        end
        data  = {8'h00, 8'h00, 8'h00, 8'h20};
        valid = 1'b1;
        step();
        check("gap_second_fire", fire_u, 4'b0001);
        // count is 2; raising persist holds fire off, lowering it fires at once
        persist = 4'd8;
        step();
        check("persist_raised_fire", fire_u, 4'b0000);
        persist = 4'd1;
        step();
        check("persist_lowered_fire", fire_u, 4'b0001);

        // signed versus unsigned relation
        do_reset();
        mode      = 2'b01;
        threshold = 8'h01;
        persist   = 4'd1;
        data      = {8'h01, 8'h01, 8'h7F, 8'h80};
        valid     = 1'b1;
        step();
        check("unsigned_lt", res_u, 4'b0000);
        check("signed_lt",   res_s, 4'b0001);
        check("signed_fire", fire_s, 4'b0001);

        // equality with a saturating two-bit counter
        do_reset();
        mode       = 2'b11;
        threshold  = 8'h55;
        persist_p2 = 2'd0;
        data       = {8'h00, 8'h00, 8'h00, 8'h55};
        valid      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("sat_fire", fire_p, 4'b0001);
            check("sat_result", res_p, 4'b0001);
        end
        persist_p2 = 2'd3;
        step();
        check("sat_max_persist_fire", fire_p, 4'b0001);

        // reset on the same edge as a valid hit
        do_reset();
        persist   = 4'd3;
        mode      = 2'b10;
        threshold = 8'h10;
        data      = {8'h00, 8'h00, 8'h00, 8'h20};
        valid     = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_result", res_u,  4'b0000);
        check("midrst_fire",   fire_u, 4'b0000);
        check("midrst_valid",  vout_u, 1'b0);
        rst = 1'b0;
        step();
        check("midrst_next_fire",   fire_u, 4'b0000);
        check("midrst_next_result", res_u,  4'b0001);
        step();
        check("midrst_second_fire", fire_u, 4'b0000);
        step();
        check("midrst_third_fire", fire_u, 4'b0001);
        valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
